// File: rtl/systolic_array_mxn.sv
// systolic_array_mxn: output-stationary ROWS x COLS integer systolic array with input skew, K-beat job control and drain.
module systolic_array_mxn #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [K_WIDTH-1:0]              k_len,
  input  logic                            acc_mode,
  output logic                            busy,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]      in_row,
  input  logic [COLS*DATA_WIDTH-1:0]      in_col,
  output logic [ROWS*COLS*ACC_WIDTH-1:0]  out_data,
  output logic                            out_valid,
  output logic                            done
);
  localparam int NA = ROWS * (ROWS - 1) / 2 > 0 ? ROWS * (ROWS - 1) / 2 : 1;
  localparam int NB = COLS * (COLS - 1) / 2 > 0 ? COLS * (COLS - 1) / 2 : 1;
  localparam int DR = ROWS + COLS - 2;
  localparam int CW = $clog2(ROWS + COLS + 1);
  localparam int PW = ACC_WIDTH > 2 * DATA_WIDTH ? ACC_WIDTH : 2 * DATA_WIDTH;
  localparam logic [CW-1:0] D_LAST = CW'(DR > 0 ? DR - 1 : 0);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state, state_n;
  logic [K_WIDTH-1:0] k_q, k_cnt;
  logic [CW-1:0] d_cnt;
  logic go, adv, last_beat, fin;

  logic [DATA_WIDTH-1:0] sa [NA];
  logic [DATA_WIDTH-1:0] sa_d [NA];
  logic [DATA_WIDTH-1:0] sb [NB];
  logic [DATA_WIDTH-1:0] sb_d [NB];
  logic [DATA_WIDTH-1:0] a_in [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_in [ROWS][COLS];
  logic [DATA_WIDTH-1:0] a_reg [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_reg [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc [ROWS][COLS];

  function automatic logic [ACC_WIDTH-1:0] mul(input logic signed [DATA_WIDTH-1:0] a,
                                               input logic signed [DATA_WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return p[ACC_WIDTH-1:0];
  endfunction

  assign go        = state == IDLE && start && k_len != '0;
  assign adv       = (state == FEED && in_valid) || state == DRAIN;
  assign last_beat = state == FEED && in_valid && k_cnt == k_q - 1'b1;
  assign fin       = state != IDLE && state_n == IDLE;
  assign busy      = state != IDLE;
  assign in_ready  = state == FEED;

  always_comb begin
    state_n = state;
    if (go) state_n = FEED;
    else if (last_beat) state_n = DR == 0 ? IDLE : DRAIN;
    else if (state == DRAIN && d_cnt == D_LAST) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      k_cnt     <= '0;
      d_cnt     <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= fin;
      out_valid <= fin | (out_valid & ~go);
      d_cnt     <= state == DRAIN ? d_cnt + 1'b1 : '0;
      if (go) begin
        k_q   <= k_len;
        k_cnt <= '0;
      end else if (state == FEED && in_valid) begin
        k_cnt <= k_cnt + 1'b1;
      end
    end
  end

  // Row i enters through a chain of i skew registers packed triangularly into sa.
  for (genvar i = 0; i < ROWS; i++) begin : g_r
    localparam int BI = i * (i - 1) / 2;
    logic [DATA_WIDTH-1:0] src;
    assign src = state == FEED ? in_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_d
      assign a_in[0][0] = src;
    end else begin : g_k
      assign sa_d[BI] = src;
      for (genvar s = 1; s < i; s++) begin : g_s
        assign sa_d[BI+s] = sa[BI+s-1];
      end
      assign a_in[i][0] = sa[BI+i-1];
    end
    for (genvar j = 1; j < COLS; j++) begin : g_c
      assign a_in[i][j] = a_reg[i][j-1];
    end
    for (genvar j = 0; j < COLS; j++) begin : g_o
      assign out_data[(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH] = acc[i][j];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_cl
    localparam int BJ = j * (j - 1) / 2;
    logic [DATA_WIDTH-1:0] src;
    assign src = state == FEED ? in_col[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (j == 0) begin : g_d
      assign b_in[0][0] = src;
    end else begin : g_k
      assign sb_d[BJ] = src;
      for (genvar s = 1; s < j; s++) begin : g_s
        assign sb_d[BJ+s] = sb[BJ+s-1];
      end
      assign b_in[0][j] = sb[BJ+j-1];
    end
    for (genvar i = 1; i < ROWS; i++) begin : g_r
      assign b_in[i][j] = b_reg[i-1][j];
    end
  end

  if (ROWS == 1) begin : g_na
    assign sa_d[0] = '0;
  end
  if (COLS == 1) begin : g_nb
    assign sb_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst || go) begin
      for (int n = 0; n < NA; n++) sa[n] <= '0;
      for (int n = 0; n < NB; n++) sb[n] <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          if (rst || !acc_mode) acc[i][j] <= '0;
        end
    end else if (adv) begin
      sa <= sa_d;
      sb <= sb_d;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_reg[i][j] <= a_in[i][j];
          b_reg[i][j] <= b_in[i][j];
          acc[i][j]   <= acc[i][j] + mul(a_in[i][j], b_in[i][j]);
        end
    end
  end
endmodule

// File: tb/tb_systolic_array_mxn.sv
// tb_systolic_array_mxn: directed checks of 2x2, 4x4 and 1x1 arrays against hand-computed results.
module tb_systolic_array_mxn;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  logic s2, am2, v2, busy2, rdy2, ov2, done2;
  logic [7:0] k2;
  logic [31:0] row2, col2;
  logic [127:0] out2;
  logic s4, am4, v4, busy4, rdy4, ov4, done4;
  logic [7:0] k4;
  logic [63:0] row4, col4;
  logic [511:0] out4;
  logic s1, am1, v1, busy1, rdy1, ov1, done1;
  logic [7:0] k1;
  logic [15:0] row1, col1;
  logic [31:0] out1;

  systolic_array_mxn #(.ROWS(2), .COLS(2)) u2 (
    .clk(clk), .rst(rst), .start(s2), .k_len(k2), .acc_mode(am2), .busy(busy2),
    .in_valid(v2), .in_ready(rdy2), .in_row(row2), .in_col(col2),
    .out_data(out2), .out_valid(ov2), .done(done2));
  systolic_array_mxn #(.ROWS(4), .COLS(4)) u4 (
    .clk(clk), .rst(rst), .start(s4), .k_len(k4), .acc_mode(am4), .busy(busy4),
    .in_valid(v4), .in_ready(rdy4), .in_row(row4), .in_col(col4),
    .out_data(out4), .out_valid(ov4), .done(done4));
  systolic_array_mxn #(.ROWS(1), .COLS(1)) u1 (
    .clk(clk), .rst(rst), .start(s1), .k_len(k1), .acc_mode(am1), .busy(busy1),
    .in_valid(v1), .in_ready(rdy1), .in_row(row1), .in_col(col1),
    .out_data(out1), .out_valid(ov1), .done(done1));

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] c2(input int c00, input int c01, input int c10, input int c11);
    return {32'(c11), 32'(c10), 32'(c01), 32'(c00)};
  endfunction

  task automatic run2(input logic am, input logic poke, input logic [127:0] exp, input string tag);
    int n;
    s2 = 1'b1; k2 = 8'd2; am2 = am;
    tick;
    s2 = poke;
    chk({tag, "_busy"}, busy2, 1);
    chk({tag, "_ov_clr"}, ov2, 0);
    chk({tag, "_rdy"}, rdy2, 1);
    v2 = 1'b1; row2 = {16'd3, 16'd1}; col2 = {16'd6, 16'd5};
    tick;
    row2 = {16'd4, 16'd2}; col2 = {16'd8, 16'd7};
    tick;
    v2 = 1'b0;
    chk({tag, "_drain_rdy"}, rdy2, 0);
    n = 1;
    while (!done2 && n < 50) begin
      tick;
      s2 = 1'b0;
      n++;
    end
    s2 = 1'b0;
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_c"}, out2, exp);
    chk({tag, "_ov"}, ov2, 1);
    chk({tag, "_idle"}, busy2, 0);
  endtask

  task automatic run1(input logic [7:0] k, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input string tag);
    s1 = 1'b1; k1 = k; am1 = 1'b0;
    tick;
    s1 = 1'b0; v1 = 1'b1; row1 = a; col1 = b;
    for (int t = 0; t < int'(k); t++) tick;
    v1 = 1'b0;
    chk({tag, "_done"}, done1, 1);
    chk({tag, "_c"}, out1, exp);
    tick;
    chk({tag, "_pulse"}, done1, 0);
  endtask

  initial begin
    logic [127:0] c1;
    logic [511:0] e4;
    int n;
    logic seen;
    rst = 1'b1;
    {s2, am2, v2, s4, am4, v4, s1, am1, v1} = '0;
    k2 = '0; k4 = '0; k1 = '0;
    row2 = '0; col2 = '0; row4 = '0; col4 = '0; row1 = '0; col1 = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy", busy2, 0);
    chk("rst_rdy", rdy2, 0);
    chk("rst_ov", ov2, 0);
    chk("rst_done", done2, 0);
    chk("rst_out", out2, 0);

    c1 = c2(19, 22, 43, 50);
    run2(1'b0, 1'b0, c1, "job1");
    repeat (3) tick;
    chk("hold_ov", ov2, 1);
    chk("hold_c", out2, c1);
    chk("hold_done", done2, 0);
    run2(1'b1, 1'b0, c2(38, 44, 86, 100), "accum");
    run2(1'b0, 1'b1, c1, "poke");

    s2 = 1'b1; k2 = 8'd0;
    tick;
    s2 = 1'b0;
    chk("k0_busy", busy2, 0);
    chk("k0_ov", ov2, 1);
    chk("k0_done", done2, 0);
    tick;
    chk("k0_c", out2, c1);

    v4 = 1'b1; row4 = '1; col4 = '1;
    tick;
    v4 = 1'b0;
    chk("idle_beat_busy", busy4, 0);
    chk("idle_beat_out", out4, 0);
    s4 = 1'b1; k4 = 8'd4; am4 = 1'b0;
    tick;
    s4 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk("id_rdy", rdy4, 1);
      v4 = 1'b1; row4 = '0; row4[t*16 +: 16] = 16'd1;
      for (int j = 0; j < 4; j++) col4[j*16 +: 16] = 16'(t * 4 + j + 1);
      tick;
      if (t < 3) begin
        v4 = 1'b0; row4 = '1; col4 = '1;
        tick;
        chk("id_bubble_rdy", rdy4, 1);
        chk("id_bubble_done", done4, 0);
        tick;
      end
    end
    v4 = 1'b0;
    n = 1;
    while (!done4 && n < 50) begin
      tick;
      n++;
    end
    chk("id_latency", n, 7);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) e4[(i*4+j)*32 +: 32] = 32'(i * 4 + j + 1);
    chk("id_c", out4, e4);
    chk("id_ov", ov4, 1);

    run1(8'd3, 16'h8000, 16'h8000, 32'hC000_0000, "wrap");
    run1(8'd1, 16'hFFFD, 16'd5, 32'hFFFF_FFF1, "neg");

    s2 = 1'b1; k2 = 8'd3; am2 = 1'b0;
    tick;
    s2 = 1'b0; v2 = 1'b1; row2 = {16'd9, 16'd9}; col2 = {16'd9, 16'd9};
    tick;
    v2 = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", busy2, 0);
    chk("mid_rst_rdy", rdy2, 0);
    chk("mid_rst_ov", ov2, 0);
    chk("mid_rst_out", out2, 0);
    chk("mid_rst_done", done2, 0);
    seen = 1'b0;
    repeat (5) begin
      tick;
      seen |= done2;
    end
    chk("mid_rst_no_done", seen, 0);
    run2(1'b0, 1'b0, c1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
